md_sched: RTL and testbench

- Sequencing and hazard controller for the multiply/divide unit in the 5-stage MIPS pipeline.
- Accepts the MD operation of the instruction in E stage and starts the multi-cycle datapath.
- Times mult/div latency, emits the busy and commit strobes and the HI/LO write strobes for mthi/mtlo.
- Generates the D-stage stall for any MD-class instruction that arrives while the unit is occupied.

---
 rtl/md_sched.sv | 105 ++++++++++
 tb/tb_md_sched.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/md_sched.sv
// Purpose: sequencing/hazard control for the MIPS multiply/divide unit (start, busy, commit, HI/LO writes, D stall).
// Latency: start combinational in cycle t; busy t+1..t+N; commit in t+N (N = MULT_CYCLES or DIV_CYCLES).
// Backpressure: stall freezes F/D while an MD-class op in D would collide with a starting or running calc.
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       op_valid_E,
    input  logic [3:0] MDop_E,
    input  logic       is_md_D,
    input  logic       abort,
    output logic       start,
    output logic       busy,
    output logic [3:0] calc_op,
    output logic       commit,
    output logic       hi_we,
    output logic       lo_we,
    output logic       stall,
    output logic       proto_err
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [4:0] MULT_N = 5'(MULT_CYCLES);
    localparam logic [4:0] DIV_N  = 5'(DIV_CYCLES);

    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    logic [0:0] state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [3:0] calc_op_q, calc_op_d;
    logic       proto_err_q, proto_err_d;

    logic is_calc_op;
    logic is_mt_op;
    logic in_idle;
    logic in_run;
    logic last_cycle;
    logic accept;

    assign is_calc_op = (MDop_E != 4'd0) && (MDop_E <= OP_DIVU);
    assign is_mt_op   = (MDop_E == OP_MTHI) || (MDop_E == OP_MTLO);
    assign in_idle    = (state_q == S_IDLE);
    assign in_run     = (state_q == S_RUN);
    assign last_cycle = in_run && (cnt_q == 5'd1);
    assign accept     = op_valid_E && is_calc_op && in_idle;

    // Combinational strobes are gated by reset so nothing leaks out while the block is held in reset.
    assign start     = reset && accept && !abort;
    assign busy      = in_run;
    assign calc_op   = calc_op_q;
    assign commit    = reset && last_cycle && !abort;
    assign hi_we     = reset && op_valid_E && (MDop_E == OP_MTHI) && in_idle && !abort;
    assign lo_we     = reset && op_valid_E && (MDop_E == OP_MTLO) && in_idle && !abort;
    assign stall     = reset && is_md_D && (start || busy);
    assign proto_err = proto_err_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        calc_op_d   = calc_op_q;
        proto_err_d = proto_err_q;

        if (in_idle) begin
            if (start) begin
                state_d   = S_RUN;
                calc_op_d = MDop_E;
                cnt_d     = (MDop_E <= OP_MULTU) ? MULT_N : DIV_N;
            end
        end else begin
            // Abort and the final count both drop back to IDLE; abort only differs by hiding commit.
            if (abort || last_cycle) begin
                state_d   = S_IDLE;
                cnt_d     = 5'd0;
                calc_op_d = 4'd0;
            end else begin
                cnt_d = cnt_q - 5'd1;
            end
            if (op_valid_E && (is_calc_op || is_mt_op)) begin
                proto_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 5'd0;
            calc_op_q   <= 4'd0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            calc_op_q   <= calc_op_d;
            proto_err_q <= proto_err_d;
        end
    end

endmodule

// File: tb/tb_md_sched.sv
// Directed-vector bench for md_sched with default MULT_CYCLES=5 / DIV_CYCLES=10.
// Output word layout: {start, busy, calc_op[3:0], commit, hi_we, lo_we, stall, proto_err}.
module tb_md_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       op_valid_E;
    logic [3:0] MDop_E;
    logic       is_md_D;
    logic       abort;
    logic       start;
    logic       busy;
    logic [3:0] calc_op;
    logic       commit;
    logic       hi_we;
    logic       lo_we;
    logic       stall;
    logic       proto_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    md_sched dut (
        .clk       (clk),
        .reset     (reset),
        .op_valid_E(op_valid_E),
        .MDop_E    (MDop_E),
        .is_md_D   (is_md_D),
        .abort     (abort),
        .start     (start),
        .busy      (busy),
        .calc_op   (calc_op),
        .commit    (commit),
        .hi_we     (hi_we),
        .lo_we     (lo_we),
        .stall     (stall),
        .proto_err (proto_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %03h expected %03h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] outs();
        return {start, busy, calc_op, commit, hi_we, lo_we, stall, proto_err};
    endfunction

    function automatic logic [10:0] ev(input logic st, input logic bz, input logic [3:0] op,
                                       input logic cm, input logic hi, input logic lo,
                                       input logic sl, input logic pe);
        return {st, bz, op, cm, hi, lo, sl, pe};
    endfunction

    // Drive one cycle's inputs just after the rising edge, check on the falling edge.
    task automatic vec(input string tag, input logic v, input logic [3:0] op, input logic d,
                       input logic ab, input logic [10:0] exp);
        op_valid_E = v;
        MDop_E     = op;
        is_md_D    = d;
        abort      = ab;
        @(negedge clk);
        check_eq(tag, {21'b0, outs()}, {21'b0, exp});
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b0;
        op_valid_E = 1'b1;
        MDop_E     = 4'd7;
        is_md_D    = 1'b1;
        abort      = 1'b0;
        #12;
        check_eq("reset_outputs", {21'b0, outs()}, 32'd0);
        MDop_E = 4'd1;
        #1;
        check_eq("reset_start_forced", {31'b0, start}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // mult with default latency
        vec("mult_c0", 1, 4'd1, 0, 0, ev(1, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 4; i++)
            vec($sformatf("mult_c%0d", i), 0, 4'd0, 0, 0, ev(0, 1, 1, 0, 0, 0, 0, 0));
        vec("mult_c5", 0, 4'd0, 0, 0, ev(0, 1, 1, 1, 0, 0, 0, 0));
        vec("mult_c6", 0, 4'd0, 0, 0, ev(0, 0, 0, 0, 0, 0, 0, 0));

        // divu with an MD-class op waiting in D
        vec("divu_c0", 1, 4'd4, 1, 0, ev(1, 0, 0, 0, 0, 0, 1, 0));
        for (int i = 1; i <= 9; i++)
            vec($sformatf("divu_c%0d", i), 0, 4'd0, 1, 0, ev(0, 1, 4, 0, 0, 0, 1, 0));
        vec("divu_c10", 0, 4'd0, 1, 0, ev(0, 1, 4, 1, 0, 0, 1, 0));
        vec("divu_c11", 0, 4'd0, 1, 0, ev(0, 0, 0, 0, 0, 0, 0, 0));

        // mthi / mtlo / mfhi / undefined op in IDLE
        vec("mthi", 1, 4'd7, 1, 0, ev(0, 0, 0, 0, 1, 0, 0, 0));
        vec("mtlo", 1, 4'd8, 1, 0, ev(0, 0, 0, 0, 0, 1, 0, 0));
        vec("mt_after", 0, 4'd0, 1, 0, ev(0, 0, 0, 0, 0, 0, 0, 0));
        vec("mfhi", 1, 4'd5, 1, 0, ev(0, 0, 0, 0, 0, 0, 0, 0));
        vec("op9_nop", 1, 4'd9, 0, 0, ev(0, 0, 0, 0, 0, 0, 0, 0));

        // abort mid-div, then a fresh mult
        vec("adiv_c0", 1, 4'd3, 0, 0, ev(1, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 3; i++)
            vec($sformatf("adiv_c%0d", i), 0, 4'd0, 0, 0, ev(0, 1, 3, 0, 0, 0, 0, 0));
        vec("adiv_c4", 0, 4'd0, 0, 1, ev(0, 1, 3, 0, 0, 0, 0, 0));
        vec("adiv_c5", 1, 4'd1, 0, 0, ev(1, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 6; i <= 9; i++)
            vec($sformatf("adiv_c%0d", i), 0, 4'd0, 0, 0, ev(0, 1, 1, 0, 0, 0, 0, 0));
        vec("adiv_c10", 0, 4'd0, 0, 0, ev(0, 1, 1, 1, 0, 0, 0, 0));
        vec("adiv_c11", 0, 4'd0, 0, 0, ev(0, 0, 0, 0, 0, 0, 0, 0));

        // abort in the commit cycle, abort at start, abort on mthi
        vec("acm_c0", 1, 4'd2, 0, 0, ev(1, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 4; i++)
            vec($sformatf("acm_c%0d", i), 0, 4'd0, 0, 0, ev(0, 1, 2, 0, 0, 0, 0, 0));
        vec("acm_c5", 0, 4'd0, 0, 1, ev(0, 1, 2, 0, 0, 0, 0, 0));
        vec("acm_c6", 0, 4'd0, 0, 0, ev(0, 0, 0, 0, 0, 0, 0, 0));
        vec("ast_c0", 1, 4'd1, 1, 1, ev(0, 0, 0, 0, 0, 0, 0, 0));
        vec("ast_c1", 0, 4'd0, 0, 0, ev(0, 0, 0, 0, 0, 0, 0, 0));
        vec("amthi", 1, 4'd7, 0, 1, ev(0, 0, 0, 0, 0, 0, 0, 0));

        // protocol violation: op ignored, calc finishes, flag sticks
        vec("viol_c0", 1, 4'd1, 0, 0, ev(1, 0, 0, 0, 0, 0, 0, 0));
        vec("viol_c1", 0, 4'd0, 0, 0, ev(0, 1, 1, 0, 0, 0, 0, 0));
        vec("viol_c2", 1, 4'd2, 0, 0, ev(0, 1, 1, 0, 0, 0, 0, 0));
        vec("viol_c3", 0, 4'd0, 0, 0, ev(0, 1, 1, 0, 0, 0, 0, 1));
        vec("viol_c4", 0, 4'd0, 0, 0, ev(0, 1, 1, 0, 0, 0, 0, 1));
        vec("viol_c5", 0, 4'd0, 0, 0, ev(0, 1, 1, 1, 0, 0, 0, 1));
        vec("viol_c6", 0, 4'd0, 0, 0, ev(0, 0, 0, 0, 0, 0, 0, 1));

        // reset mid-operation clears everything at once
        vec("rst_c0", 1, 4'd1, 0, 0, ev(1, 0, 0, 0, 0, 0, 0, 1));
        vec("rst_c1", 0, 4'd0, 0, 0, ev(0, 1, 1, 0, 0, 0, 0, 1));
        vec("rst_c2", 1, 4'd2, 0, 0, ev(0, 1, 1, 0, 0, 0, 0, 1));
        reset = 1'b0;
        #1;
        check_eq("rst_async", {21'b0, outs()}, 32'd0);
        vec("rst_held", 1, 4'd1, 1, 0, ev(0, 0, 0, 0, 0, 0, 0, 0));
        reset = 1'b1;
        vec("rst_rel_c0", 1, 4'd3, 1, 0, ev(1, 0, 0, 0, 0, 0, 1, 0));
        vec("rst_rel_c1", 0, 4'd0, 0, 0, ev(0, 1, 3, 0, 0, 0, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
